// File: rtl/scytale_crypt_if.sv
// Character stream interface of the scytale engine: input stream, key/mode
// selection and the backpressured output stream.
interface scytale_crypt_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic                 mode_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 ready_i;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 done_o;
  logic                 overflow_o;

  modport master (
    output data_i, valid_i, mode_i, key_N, key_M, ready_i,
    input  busy, data_o, valid_o, done_o, overflow_o
  );

  modport slave (
    input  data_i, valid_i, mode_i, key_N, key_M, ready_i,
    output busy, data_o, valid_o, done_o, overflow_o
  );
endinterface

// File: rtl/scytale_crypt.sv
// Scytale cipher engine: buffers a message until the start token, then emits
// it column-strided (stride key_N to decrypt, key_M to encrypt).
module scytale_crypt #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input logic           clk,
  input logic           rst_n,
  scytale_crypt_if.slave io
);

  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int IW = AW + KEY_WIDTH + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NOF_CHARS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t               state;
  logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
  logic [CW-1:0]        n_q;
  logic [KEY_WIDTH-1:0] s_q;
  logic [IW-1:0]        r_q;
  logic [IW-1:0]        k_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [D_WIDTH-1:0]   data_q;

  logic                 is_token;
  logic                 wr_en;
  logic [KEY_WIDTH-1:0] s_sel;
  logic [IW-1:0]        n_ext;
  logic [IW-1:0]        s_ext;
  logic [IW-1:0]        k_step;
  logic [IW-1:0]        r_step;
  logic [IW-1:0]        nxt_k;
  logic [IW-1:0]        nxt_r;
  logic                 last;
  logic [AW-1:0]        rd_addr;

  assign is_token = (io.data_i == START_DECRYPTION_TOKEN);
  assign wr_en    = (state == LOAD) && io.valid_i && !is_token && (n_q < MAX_C);
  assign s_sel    = io.mode_i ? io.key_M : io.key_N;
  assign n_ext    = IW'(n_q);
  assign s_ext    = IW'(s_q);
  assign k_step   = k_q + s_ext;
  assign r_step   = r_q + IW'(1);
  assign rd_addr  = nxt_k[AW-1:0];

  // Next index to present; an exhausted row jumps straight to the next row
  // start, and a row start past n means every later row is empty too.
  always_comb begin
    nxt_k = k_step;
    nxt_r = r_q;
    last  = 1'b0;
    if (k_step < n_ext) begin
      nxt_k = k_step;
    end else if ((r_step < s_ext) && (r_step < n_ext)) begin
      nxt_r = r_step;
      nxt_k = r_step;
    end else begin
      last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[n_q[AW-1:0]] <= io.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      n_q        <= '0;
      s_q        <= KEY_WIDTH'(1);
      r_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        LOAD: begin
          if (io.valid_i) begin
            if (is_token) begin
              s_q    <= (s_sel == '0) ? KEY_WIDTH'(1) : s_sel;
              r_q    <= '0;
              k_q    <= '0;
              busy_q <= 1'b1;
              state  <= EMIT;
              if (n_q != '0) begin
                valid_q <= 1'b1;
                data_q  <= mem[0];
              end
            end else if (n_q < MAX_C) begin
              n_q <= n_q + ONE_C;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          // valid_q low here only for an empty message, which ends at once
          if (!valid_q || (io.ready_i && last)) begin
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            n_q        <= '0;
            overflow_q <= 1'b0;
            state      <= LOAD;
          end else if (io.ready_i) begin
            k_q    <= nxt_k;
            r_q    <= nxt_r;
            data_q <= mem[rd_addr];
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign io.busy       = busy_q;
  assign io.valid_o    = valid_q;
  assign io.done_o     = done_q;
  assign io.overflow_o = overflow_q;
  assign io.data_o     = data_q;

endmodule

// File: tb/tb_scytale_crypt.sv
// Bench for scytale_crypt: literal expected strings are queued per message and
// popped by a monitor on every output handshake.
module tb_scytale_crypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scytale_crypt_if #(.D_WIDTH(8), .KEY_WIDTH(8)) io ();

  scytale_crypt #(
    .D_WIDTH(8), .KEY_WIDTH(8), .MAX_NOF_CHARS(50), .START_DECRYPTION_TOKEN(8'hFA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  logic [7:0] exp_q[$];
  logic [7:0] exp_c;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int hs0 = 0;
  int d0 = 0;
  logic prev_stall = 1'b0;
  logic prev_done = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic bp_en = 1'b0;
  logic ready_lvl = 1'b1;
  int bp_cnt = 0;

  // ready_i has a single driver: either a level or the 1,0,0,1 stall pattern
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      io.ready_i = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
      bp_cnt++;
    end else begin
      io.ready_i = ready_lvl;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(io.valid_o === 1'b1 && io.data_o === prev_data)) begin
          errors++;
          $display("[TB] FAIL stall_hold: valid_o=%b data_o=%h, required valid_o=1 data_o=%h",
                   io.valid_o, io.data_o, prev_data);
        end
      end
      if (io.valid_o === 1'b1 && io.ready_i === 1'b1) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: data_o=%h, required no output", io.data_o);
        end else begin
          exp_c = exp_q.pop_front();
          if (io.data_o !== exp_c) begin
            errors++;
            $display("[TB] FAIL output_char: data_o=%h, required %h", io.data_o, exp_c);
          end
        end
      end
      if (io.done_o === 1'b1) begin
        done_cnt++;
        checks++;
        if (prev_done || io.valid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_pulse: prev_done=%b valid_o=%b, required 0 and 0",
                   prev_done, io.valid_o);
        end
      end
      prev_stall = (io.valid_o === 1'b1) && (io.ready_i !== 1'b1);
      prev_data  = io.data_o;
      prev_done  = (io.done_o === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic arm(input string expect_s);
    hs0 = hs_cnt;
    d0  = done_cnt;
    for (int i = 0; i < expect_s.len(); i++) exp_q.push_back(expect_s[i]);
  endtask

  task automatic drive_msg(input string msg, input logic mode, input logic [7:0] kn,
                           input logic [7:0] km);
    io.mode_i = mode;
    io.key_N  = kn;
    io.key_M  = km;
    for (int i = 0; i < msg.len(); i++) begin
      io.valid_i = 1'b1;
      io.data_i  = msg[i];
      @(posedge clk); #1;
    end
    io.valid_i = 1'b1;
    io.data_i  = 8'hFA;
    @(posedge clk); #1;
    io.valid_i = 1'b0;
    io.data_i  = 8'h00;
  endtask

  task automatic finish_msg(input string name, input int exp_len);
    bit got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (done_cnt > d0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s_timeout: done_o not seen, required one pulse", name);
    end
    checks++;
    if (hs_cnt - hs0 != exp_len) begin
      errors++;
      $display("[TB] FAIL %s_count: emitted %0d, required %0d", name, hs_cnt - hs0, exp_len);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_leftover: %0d chars pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (io.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy_after: busy=%b, required 0", name, io.busy);
    end
  endtask

  task automatic run_msg(input string name, input string msg, input logic mode,
                         input logic [7:0] kn, input logic [7:0] km, input string expect_s);
    arm(expect_s);
    drive_msg(msg, mode, kn, km);
    finish_msg(name, expect_s.len());
  endtask

  task automatic test_reset();
    io.valid_i = 1'b0;
    io.data_i  = 8'h00;
    io.mode_i  = 1'b0;
    io.key_N   = 8'd0;
    io.key_M   = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({io.busy, io.valid_o, io.done_o, io.overflow_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: busy/valid/done/ovf=%b, required 0000",
               {io.busy, io.valid_o, io.done_o, io.overflow_o});
    end
    checks++;
    if (io.data_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: data_o=%h, required 00", io.data_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decrypt();
    arm("ACEBDF");
    drive_msg("ABCDEF", 1'b0, 8'd2, 8'd3);
    io.key_N = 8'd5;
    checks++;
    if (io.busy !== 1'b1 || io.valid_o !== 1'b1 || io.data_o !== "A") begin
      errors++;
      $display("[TB] FAIL decrypt_latency: busy=%b valid_o=%b data_o=%h, required 1 1 41",
               io.busy, io.valid_o, io.data_o);
    end
    finish_msg("decrypt", 6);
  endtask

  task automatic test_encrypt();
    run_msg("encrypt", "ACEBDF", 1'b1, 8'd7, 8'd3, "ABCDEF");
    run_msg("decrypt7", "ABCDEFG", 1'b0, 8'd3, 8'd9, "ADGBECF");
  endtask

  task automatic test_backpressure();
    arm("ACEBDF");
    drive_msg("ABCDEF", 1'b0, 8'd2, 8'd3);
    bp_cnt = 0;
    bp_en  = 1'b1;
    finish_msg("backpressure", 6);
    bp_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    hs0 = hs_cnt;
    d0  = done_cnt;
    io.mode_i = 1'b0;
    io.key_N  = 8'd1;
    io.key_M  = 8'd4;
    for (int i = 0; i < 52; i++) begin
      if (i < 50) exp_q.push_back(8'h30 + 8'(i));
      io.valid_i = 1'b1;
      io.data_i  = 8'h30 + 8'(i);
      @(posedge clk); #1;
      if (i == 49 || i == 50) begin
        checks++;
        if (io.overflow_o !== (i == 50)) begin
          errors++;
          $display("[TB] FAIL overflow_at_%0d: overflow_o=%b, required %b",
                   i + 1, io.overflow_o, (i == 50));
        end
      end
    end
    io.valid_i = 1'b1;
    io.data_i  = 8'hFA;
    @(posedge clk); #1;
    io.valid_i = 1'b0;
    finish_msg("overflow", 50);
    checks++;
    if (io.overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: overflow_o=%b, required 0", io.overflow_o);
    end
  endtask

  task automatic test_edge_keys();
    run_msg("key_zero", "HELLO", 1'b0, 8'd0, 8'd3, "HELLO");
    arm("");
    drive_msg("", 1'b0, 8'd2, 8'd2);
    checks++;
    if (io.busy !== 1'b1 || io.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_busy: busy=%b valid_o=%b, required 1 0", io.busy, io.valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (io.busy !== 1'b0 || io.done_o !== 1'b1 || io.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_done: busy=%b done_o=%b valid_o=%b, required 0 1 0",
               io.busy, io.done_o, io.valid_o);
    end
    finish_msg("empty", 0);
  endtask

  task automatic test_busy_input();
    ready_lvl = 1'b0;
    arm("ADBECF");
    drive_msg("ABCDEF", 1'b0, 8'd3, 8'd2);
    for (int j = 0; j < 6; j++) begin
      io.valid_i = 1'b1;
      io.data_i  = (j % 2 == 1) ? 8'hFA : "Q";
      @(posedge clk); #1;
    end
    io.valid_i = 1'b0;
    ready_lvl  = 1'b1;
    finish_msg("busy_input", 6);
    run_msg("after_busy", "XYZ", 1'b0, 8'd2, 8'd5, "XZY");
  endtask

  task automatic test_async_reset();
    ready_lvl = 1'b0;
    arm("ACEBDF");
    drive_msg("ABCDEF", 1'b0, 8'd2, 8'd3);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.busy !== 1'b0 || io.valid_o !== 1'b0 || io.data_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: busy=%b valid_o=%b data_o=%h, required 0 0 00",
               io.busy, io.valid_o, io.data_o);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_lvl = 1'b1;
    @(posedge clk); #1;
    run_msg("post_reset", "XY", 1'b0, 8'd1, 8'd3, "XY");
  endtask

  initial begin
    test_reset();
    test_decrypt();
    test_encrypt();
    test_backpressure();
    test_overflow();
    test_edge_keys();
    test_busy_input();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scytale_crypt.md
Name: scytale_crypt

Overview:
- Parametrised scytale cipher engine: collects a character stream, then emits it re-ordered.
- Decrypts (stride key_N) or encrypts (stride key_M), selected per message.
- Adds output backpressure, overflow detection and an end-of-message pulse.
- Sits between the byte demux and the output mux of the decryption datapath, alongside the other cipher blocks.

Parameters:
- D_WIDTH, 8: character width in bits.
- KEY_WIDTH, 8: width of key_N and key_M.
- MAX_NOF_CHARS, 50: buffer depth in characters.
- START_DECRYPTION_TOKEN, 8'hFA: end-of-input / start-processing token, compared on the full data_i width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- data_i, input, D_WIDTH: input character or token.
- valid_i, input, 1: data_i qualifier.
- mode_i, input, 1: 0 = decrypt, 1 = encrypt.
- key_N, input, KEY_WIDTH: matrix columns.
- key_M, input, KEY_WIDTH: matrix rows.
- ready_i, input, 1: downstream accepts data_o this cycle.
- busy, output, 1: engine is emitting; input is ignored.
- data_o, output, D_WIDTH: output character.
- valid_o, output, 1: data_o qualifier.
- done_o, output, 1: one-cycle pulse at end of message.
- overflow_o, output, 1: sticky flag; characters were dropped.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to LOAD.
  - busy, valid_o, done_o and overflow_o are 0; data_o is 0.
  - Count n is 0; the buffer need not be cleared.
- Reset mid-operation aborts immediately. There is no partial output after release.

- State LOAD (busy=0):
  - On valid_i with data_i != token and n < MAX_NOF_CHARS: store the character at buf[n], then n <= n+1.
  - On valid_i with data_i != token and n == MAX_NOF_CHARS: drop the character and set overflow_o.
  - On valid_i with data_i == token:
    - Latch S = (mode_i ? key_M : key_N); S=0 is treated as 1.
    - Set r=0, k=0 and go to EMIT.
    - busy rises at the same edge.
  - Keys and mode are sampled only at token acceptance. Later changes have no effect on the current message.

- State EMIT (busy=1, valid_i ignored, including tokens):
  - Implements: for r in 0..S-1, for k=r; k<n; k+=S, emit buf[k].
  - The first character is valid the cycle after token acceptance (latency 1). It is registered.
  - data_o/valid_o hold stable while valid_o=1 and ready_i=0.
  - Advance only on valid_o & ready_i.
  - Index arithmetic is at least clog2(MAX_NOF_CHARS)+KEY_WIDTH+1 bits wide; k+S never wraps.
  - Rows whose start r >= n emit nothing and are skipped without bubbles. The output is contiguous while ready_i=1, with at most 1 idle cycle per row change.
  - Total emitted is exactly n characters.
  - On the final handshake:
    - done_o pulses for 1 cycle (same cycle valid_o drops).
    - busy falls.
    - State returns to LOAD; n=0, overflow_o clears.
  - Empty message (token with n=0):
    - busy is high for exactly 1 cycle.
    - No valid_o.
    - done_o pulses in that cycle's following edge.

- Cipher relations:
  - Decrypting with stride N inverts encrypting with stride M when n = N*M.
  - With n not a multiple of S, the loop semantics above are authoritative.

- data_o outside valid_o: holds its last value. It is 0 only after reset.

Test Plan:
- Decrypt: key_N=2, key_M=3, mode 0, input "ABCDEF" then 0xFA, ready_i=1 → valid_o for 6 consecutive-or-row-gapped cycles. Output "ACEBDF", first char 1 cycle after the token, done_o single pulse, busy low afterwards.
- Encrypt round-trip: mode 1, key_M=3, input "ACEBDF"+0xFA → output "ABCDEF". Also mode 0, key_N=3, input "ABCDEFG" (n=7) → "ADGBECF".
- Backpressure: repeat test 1 with ready_i toggling 1,0,0,1… → data_o stable while stalled, identical sequence "ACEBDF", no duplicates or drops.
- Overflow: 52 non-token chars then token, MAX_NOF_CHARS=50 → overflow_o=1 from the 51st char, exactly 50 chars emitted, overflow_o cleared after done_o.
- Edge keys and input during busy: key_N=0 → pass-through order; token with n=0 → 1-cycle busy, no valid_o; chars and tokens driven while busy are ignored, and the next message is processed correctly.
- Async reset: assert rst_n=0 between clock edges mid-EMIT → busy/valid_o drop immediately. After release, a new message "XY"+token with key_N=1 yields "XY".
